// File: rtl/port_reader_pkg.sv
// Shared switch definitions: port reader state encoding and default widths.
package port_reader_pkg;

    localparam int W_WIDTH_DEF   = 8;
    localparam int ERR_CNT_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_LEN,
        ST_RD_DATA,
        ST_RD_PARITY,
        ST_DRAIN
    } rd_state_e;

endpackage

// File: rtl/port_reader_if.sv
// Output byte stream of the port reader: valid/ready handshake plus framing flags.
interface port_reader_if
    import port_reader_pkg::*;
#(
    parameter int W_WIDTH = W_WIDTH_DEF
);

    logic               out_valid;
    logic               out_ready;
    logic [W_WIDTH-1:0] out_data;
    logic               out_sop;
    logic               out_eop;
    logic               parity_err;

    modport master (
        output out_valid, out_data, out_sop, out_eop, parity_err,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_sop, out_eop, parity_err,
        output out_ready
    );

endinterface

// File: rtl/port_reader_parity_acc.sv
// Running XOR of a packet's bytes; clr restarts the sum at the current byte.
module parity_acc #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] acc,
    output logic         mismatch
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= din;
        end else if (en) begin
            acc <= acc ^ din;
        end
    end

    assign mismatch = (acc != din);

endmodule

// File: rtl/port_reader.sv
// Reads addr/len/data/parity packets from a show-ahead FIFO into a registered byte stream.
module port_reader
    import port_reader_pkg::*;
#(
    parameter int W_WIDTH   = W_WIDTH_DEF,
    parameter int ERR_CNT_W = ERR_CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 port_en,
    input  logic                 fifo_empty,
    input  logic [W_WIDTH-1:0]   fifo_data,
    output logic                 fifo_rd_en,
    output logic                 port_busy,
    output logic [ERR_CNT_W-1:0] err_cnt,
    port_reader_if.master        out
);

    localparam logic [W_WIDTH-1:0]   CNT_ONE = W_WIDTH'(1);
    localparam logic [ERR_CNT_W-1:0] ERR_ONE = ERR_CNT_W'(1);

    rd_state_e          state_q, state_d;
    logic [W_WIDTH-1:0] cnt_q;
    logic               can_load;
    logic               ld;
    logic               acc_clr, acc_en;
    logic               cnt_load, cnt_dec;
    logic [W_WIDTH-1:0] acc;
    logic               mismatch;

    parity_acc #(.W(W_WIDTH)) u_parity_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (acc_clr),
        .en       (acc_en),
        .din      (fifo_data),
        .acc      (acc),
        .mismatch (mismatch)
    );

    assign can_load = !fifo_empty && (!out.out_valid || out.out_ready);

    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        ld       = 1'b0;
        acc_clr  = 1'b0;
        acc_en   = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (port_en && can_load) begin
                    ld      = 1'b1;
                    acc_clr = 1'b1;
                    state_d = ST_RD_LEN;
                end
            end
            ST_RD_LEN: begin
                if (can_load) begin
                    ld       = 1'b1;
                    acc_en   = 1'b1;
                    cnt_load = 1'b1;
                    state_d  = (fifo_data == '0) ? ST_RD_PARITY : ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (can_load) begin
                    ld      = 1'b1;
                    acc_en  = 1'b1;
                    cnt_dec = 1'b1;
                    if (cnt_q == CNT_ONE) state_d = ST_RD_PARITY;
                end
            end
            ST_RD_PARITY: begin
                if (can_load) begin
                    ld      = 1'b1;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out.out_valid && out.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The pop strobe is gated by reset so the FIFO is never drained while held in reset.
    assign fifo_rd_en = ld && rst_n;
    assign port_busy  = (state_q != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (cnt_load)     cnt_q <= fifo_data;
            else if (cnt_dec) cnt_q <= cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out.out_valid  <= 1'b0;
            out.out_data   <= '0;
            out.out_sop    <= 1'b0;
            out.out_eop    <= 1'b0;
            out.parity_err <= 1'b0;
            err_cnt        <= '0;
        end else begin
            if (ld) begin
                out.out_valid  <= 1'b1;
                out.out_data   <= fifo_data;
                out.out_sop    <= (state_q == ST_IDLE);
                out.out_eop    <= (state_q == ST_RD_PARITY);
                out.parity_err <= (state_q == ST_RD_PARITY) && mismatch;
            end else if (out.out_ready) begin
                out.out_valid  <= 1'b0;
            end
            if (ld && (state_q == ST_RD_PARITY) && mismatch && (err_cnt != '1)) begin
                err_cnt <= err_cnt + ERR_ONE;
            end
        end
    end

endmodule

// File: tb/tb_port_reader.sv
// Directed and random packet traffic against a queue-based model of the port reader stream.
module tb_port_reader;
    import port_reader_pkg::*;

    localparam int W  = W_WIDTH_DEF;
    localparam int EW = ERR_CNT_W_DEF;

    typedef struct packed {
        logic         perr;
        logic         eop;
        logic         sop;
        logic [W-1:0] data;
    } beat_t;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b1;
    logic          port_en = 1'b0;
    logic          fifo_empty, fifo_rd_en, port_busy;
    logic [W-1:0]  fifo_data;
    logic [EW-1:0] err_cnt;

    port_reader_if #(.W_WIDTH(W)) out_if ();

    port_reader #(.W_WIDTH(W), .ERR_CNT_W(EW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .port_en    (port_en),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .port_busy  (port_busy),
        .err_cnt    (err_cnt),
        .out        (out_if)
    );

    always #5 clk = ~clk;

    // Show-ahead FIFO model: written by the stimulus, popped on fifo_rd_en.
    logic [W-1:0] mem [256];
    int           wr_ptr = 0;
    int           rd_ptr = 0;
    logic         flush  = 1'b0;
    int           underflows = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_data  = mem[8'(rd_ptr)];

    always @(posedge clk) begin
        if (flush) rd_ptr <= wr_ptr;
        else if (fifo_rd_en) begin
            if (fifo_empty) underflows <= underflows + 1;
            else            rd_ptr     <= rd_ptr + 1;
        end
    end

    // Monitor: records every accepted output byte with its cycle number.
    beat_t rx_q[$];
    int    rx_cyc[$];
    int    cyc      = 0;
    int    busy_cnt = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && port_busy) busy_cnt <= busy_cnt + 1;
        if (rst_n && out_if.out_valid && out_if.out_ready) begin
            rx_q.push_back('{perr: out_if.parity_err, eop: out_if.out_eop,
                             sop: out_if.out_sop, data: out_if.out_data});
            rx_cyc.push_back(cyc);
        end
    end

    // Reference model state
    beat_t        exp_q[$];
    logic [W-1:0] src_q[$];
    logic [W-1:0] pkt[$];
    int           exp_err     = 0;
    int           rx_base     = 0;
    int           vectors     = 0;
    int           miscompares = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Expected stream for pkt: parity is the XOR of every byte but the last.
    task automatic add_pkt();
        logic [W-1:0] x;
        logic         perr;
        int           n;
        n = pkt.size();
        x = '0;
        for (int k = 0; k < n - 1; k++) x ^= pkt[k];
        perr = (x != pkt[n-1]);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back('{perr: (k == n - 1) && perr, eop: (k == n - 1),
                              sop: (k == 0), data: pkt[k]});
            src_q.push_back(pkt[k]);
        end
        if (perr && exp_err < (1 << EW) - 1) exp_err++;
    endtask

    task automatic rand_pkt(input int max_len, input int corrupt_pct);
        logic [W-1:0] par;
        int           len;
        pkt.delete();
        len = $urandom_range(0, max_len);
        pkt.push_back(8'($urandom));
        pkt.push_back(8'(len));
        for (int k = 0; k < len; k++) pkt.push_back(8'($urandom));
        par = '0;
        foreach (pkt[k]) par ^= pkt[k];
        if ($urandom_range(0, 99) < corrupt_pct) par ^= 8'($urandom_range(1, 255));
        pkt.push_back(par);
        add_pkt();
    endtask

    task automatic push_n(input int n);
        for (int k = 0; k < n && src_q.size() > 0; k++) begin
            mem[8'(wr_ptr)] = src_q.pop_front();
            wr_ptr++;
        end
    endtask

    task automatic wait_rx(input string tag, input int n, input int budget);
        int t;
        t = 0;
        while (rx_q.size() < n && t < budget) begin
            @(negedge clk);
            #1;
            t++;
        end
        check(tag, 32'(rx_q.size() >= n), 32'd1);
    endtask

    task automatic check_rx(input string tag);
        int    n;
        beat_t obs;
        n = exp_q.size();
        wait_rx({tag, "_wait"}, rx_base + n, 4000);
        for (int i = 0; i < n; i++) begin
            obs = (rx_base + i < rx_q.size()) ? rx_q[rx_base + i] : '1;
            check($sformatf("%s_beat%0d", tag, i), 32'(obs), 32'(exp_q[i]));
        end
        rx_base += n;
        exp_q.delete();
    endtask

    initial begin
        int busy0;
        int guard;
        out_if.out_ready = 1'b1;
        #2 rst_n = 1'b0;

        // Reset state, with a packet already queued and port_en high
        port_en = 1'b1;
        pkt = {8'h05, 8'h02, 8'hAA, 8'h55, 8'hF8};
        add_pkt();
        push_n(5);
        @(negedge clk);
        check("rst_rd_en",  32'(fifo_rd_en),        32'd0);
        check("rst_valid",  32'(out_if.out_valid),  32'd0);
        check("rst_data",   32'(out_if.out_data),   32'd0);
        check("rst_flags",  32'({out_if.out_sop, out_if.out_eop, out_if.parity_err}), 32'd0);
        check("rst_busy",   32'(port_busy),         32'd0);
        check("rst_errcnt", 32'(err_cnt),           32'd0);

        // Basic packet: five consecutive bytes, busy for five cycles
        busy0 = busy_cnt;
        step();
        rst_n = 1'b1;
        check_rx("basic");
        for (int i = 1; i < 5; i++)
            check($sformatf("basic_gap%0d", i), 32'(rx_cyc[i] - rx_cyc[0]), 32'(i));
        repeat (3) step();
        check("basic_busy", 32'(busy_cnt - busy0), 32'd5);
        check("basic_err",  32'(err_cnt), 32'(exp_err));

        // Bad parity byte
        pkt = {8'h05, 8'h02, 8'hAA, 8'h55, 8'hF9};
        add_pkt();
        push_n(5);
        check_rx("badpar");
        check("badpar_err", 32'(err_cnt), 32'd1);

        // Zero-length packet
        pkt = {8'h03, 8'h00, 8'h03};
        add_pkt();
        push_n(3);
        check_rx("len0");

        // Downstream backpressure right after sop
        repeat (2) step();
        out_if.out_ready = 1'b0;
        pkt = {8'h05, 8'h02, 8'hAA, 8'h55, 8'hF8};
        add_pkt();
        push_n(5);
        guard = 0;
        while (!out_if.out_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("bp_sop", 32'({out_if.out_sop, out_if.out_data}), 32'h105);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d", i), 32'({fifo_rd_en, out_if.out_data}), 32'h005);
        end
        step();
        out_if.out_ready = 1'b1;
        check_rx("bp");

        // FIFO runs dry after len byte; port_en drops meanwhile
        pkt = {8'h21, 8'h03, 8'h10, 8'h20, 8'h30, 8'h21 ^ 8'h03 ^ 8'h10 ^ 8'h20 ^ 8'h30};
        add_pkt();
        push_n(2);
        wait_rx("dry_len", rx_base + 2, 50);
        for (int i = 0; i < 3; i++) begin
            step();
            if (i == 1) port_en = 1'b0;
            check($sformatf("dry_stall%0d", i), 32'({port_busy, fifo_rd_en}), 32'b10);
        end
        push_n(4);
        check_rx("dry");
        rand_pkt(4, 0);
        push_n(src_q.size());
        repeat (6) step();
        check("gate_idle", 32'({port_busy, fifo_rd_en, out_if.out_valid}), 32'b000);
        check("gate_norx", 32'(rx_q.size()), 32'(rx_base));
        port_en = 1'b1;
        check_rx("gate");

        // Random traffic with random FIFO gaps and downstream stalls
        for (int p = 0; p < 20; p++) rand_pkt(8, 30);
        guard = 0;
        while (rx_q.size() < rx_base + exp_q.size() && guard < 6000) begin
            step();
            out_if.out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) < 7) push_n(1);
            guard++;
        end
        out_if.out_ready = 1'b1;
        check_rx("rand");
        check("rand_err", 32'(err_cnt), 32'(exp_err));

        // Reset pulse after the second data byte
        pkt = {8'h44, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h44 ^ 8'h04 ^ 8'h01 ^ 8'h02 ^ 8'h03 ^ 8'h04};
        add_pkt();
        push_n(7);
        wait_rx("mid_wait", rx_base + 4, 50);
        rst_n = 1'b0;
        #1;
        check("mid_valid", 32'(out_if.out_valid), 32'd0);
        check("mid_data",  32'(out_if.out_data),  32'd0);
        check("mid_flags", 32'({out_if.out_sop, out_if.out_eop, out_if.parity_err}), 32'd0);
        check("mid_busy",  32'({port_busy, fifo_rd_en}), 32'd0);
        check("mid_err",   32'(err_cnt), 32'd0);
        exp_q.delete();
        src_q.delete();
        exp_err = 0;
        rx_base = rx_q.size();
        flush = 1'b1;
        step();
        flush = 1'b0;
        port_en = 1'b0;
        src_q.push_back(8'h11);
        push_n(1);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_nopop", 32'({fifo_rd_en, out_if.out_valid}), 32'd0);
        step();
        check("rel_norx", 32'(rx_q.size()), 32'(rx_base));
        flush = 1'b1;
        step();
        flush = 1'b0;

        // Error counter saturation
        port_en = 1'b1;
        for (int i = 0; i < 256; i++) begin
            pkt = {8'(i), 8'h00, ~8'(i)};
            add_pkt();
            push_n(3);
            check_rx("sat");
            if (i >= 254) check($sformatf("sat_cnt%0d", i), 32'(err_cnt), 32'(exp_err));
        end
        check("sat_final", 32'(err_cnt), 32'd255);
        check("underflow", 32'(underflows), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/port_reader.md
PORT_READER -- requirements
Module: port_reader

Interface
REQ-001 Parameter W_WIDTH, 8, byte width of FIFO data and output bus.
REQ-002 Parameter ERR_CNT_W, 8, width of saturating parity-error counter.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 port_en  input  1  permits start of a new packet; does not abort a packet in flight.
REQ-006 fifo_empty  input  1  port FIFO empty flag (show-ahead FIFO).
REQ-007 fifo_data  input  W_WIDTH  head-of-FIFO byte, valid whenever fifo_empty=0.
REQ-008 fifo_rd_en  output  1  pop strobe; combinational.
REQ-009 out_valid  output  W_WIDTH-independent 1  output byte valid.
REQ-010 out_ready  input  1  downstream accepts byte when out_valid=1 and out_ready=1.
REQ-011 out_data  output  W_WIDTH  registered output byte.
REQ-012 out_sop  output  1  marks address byte.
REQ-013 out_eop  output  1  marks parity byte.
REQ-014 parity_err  output  1  qualifies eop byte: received parity mismatched.
REQ-015 port_busy  output  1  packet in flight; feeds writer-side port_busy.
REQ-016 err_cnt  output  ERR_CNT_W  saturating count of parity errors.

Function
REQ-017 Packet in FIFO SHALL be: addr byte, len byte (0..255), len data bytes, parity byte = XOR of addr, len and all data bytes.
REQ-018 Output register load condition "ld" SHALL be: state active for a byte, fifo_empty=0, and (out_valid=0 or out_ready=1); fifo_rd_en = ld.
REQ-019 A popped byte SHALL appear on out_data with out_valid=1 exactly one cycle after the pop; it SHALL hold stable until accepted.
REQ-020 out_valid SHALL clear on acceptance when no ld occurs in the same cycle; back-to-back ld with out_ready=1 SHALL sustain one byte per cycle.
REQ-021 States: IDLE, RD_LEN, RD_DATA, RD_PARITY, DRAIN.
REQ-022 IDLE: on port_en=1 and ld, pop addr, set out_sop with it, clear parity accumulator to addr, assert port_busy next cycle, go RD_LEN; otherwise stay, no pop.
REQ-023 RD_LEN: on ld, load byte counter with len, XOR into accumulator; len=0 -> RD_PARITY, else RD_DATA.
REQ-024 RD_DATA: each ld decrements counter and XORs byte; on the pop leaving counter 0 -> RD_PARITY.
REQ-025 RD_PARITY: on ld, set out_eop; parity_err = (accumulator != byte); err_cnt increments if error, saturating at all-ones; go DRAIN.
REQ-026 DRAIN: no pops; on acceptance of eop byte deassert port_busy and go IDLE in the same edge.
REQ-027 fifo_empty=1 mid-packet SHALL stall the current state without error; out_ready=0 SHALL stall pops.
REQ-028 port_en falling mid-packet SHALL have no effect until IDLE is reached.
REQ-029 out_sop, out_eop, parity_err SHALL be registered alongside out_data and only meaningful while out_valid=1.

Reset
REQ-030 rst_n=0 SHALL immediately force state IDLE, out_valid=0, out_data=0, out_sop=0, out_eop=0, parity_err=0, port_busy=0, err_cnt=0, counter and accumulator 0; fifo_rd_en=0 while in reset.
REQ-031 Reset mid-packet SHALL discard the partial packet; no byte is popped in the first cycle after release unless IDLE entry conditions hold.

Structure
REQ-032 State encodings and W_WIDTH default SHALL live in the shared switch package used by the writer FSM.
REQ-033 Parity accumulate/compare SHALL be a sub-module parity_acc (clear, enable, data in, running XOR out).

Verification
REQ-034 FIFO holds 05,02,AA,55,F8; out_ready=1 -> 5 consecutive out bytes, sop on 05, eop on F8, parity_err=0, port_busy high 5 cycles.
REQ-035 Same packet with parity byte F9 -> eop byte F9 with parity_err=1, err_cnt=1.
REQ-036 Packet 03,00,03 (len 0) -> three bytes, eop on 03, parity_err=0.
REQ-037 out_ready held 0 for 4 cycles after sop -> out_data stays 05, fifo_rd_en=0 throughout, then resumes without loss.
REQ-038 fifo_empty=1 for 3 cycles after len byte, port_en dropped meanwhile -> packet completes; next queued packet not started until port_en=1.
REQ-039 rst_n pulsed low after second data byte -> all outputs to reset values same cycle; err_cnt 255 plus one error stays 255.
